// File: rtl/pc_fetch_pkg.sv
// pc_fetch_pkg: shared fetch-state encoding and constants for the PC/fetch sequencer
package pc_fetch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        DROP
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] NOP_INS          = 32'h0000_0000;

endpackage

// File: rtl/pc_fetch.sv
// pc_fetch: PC register and instruction-fetch sequencer; PC_FETCH_ALIGN_CHK_EN enables the misaligned-fetch trap
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] pc,
    input  logic [31:0] npc,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ins,
    output logic        ins_valid,
    input  logic        ins_ready,
    output logic        fetch_err
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  ins_q, ins_d;
    logic [31:0]  imem_addr_q, imem_addr_d;
    logic         ins_valid_q, ins_valid_d;
    logic         imem_req_q, imem_req_d;
`ifdef PC_FETCH_ALIGN_CHK_EN
    logic         fetch_err_q, fetch_err_d;
`endif

    // Next-state, next-PC and registered-output computation; flush outranks every other event
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ins_d       = ins_q;
        ins_valid_d = ins_valid_q;
        case (state_q)
            IDLE: begin
                state_d = REQ;
                if (flush) pc_d = flush_pc;
            end
            REQ: begin
                if (flush) begin
                    pc_d    = flush_pc;
                    state_d = (imem_gnt && imem_req_q) ? DROP : REQ;
                end else if (!imem_req_q) begin
                    state_d     = HOLD;
                    ins_d       = NOP_INS;
                    ins_valid_d = 1'b1;
                end else if (imem_gnt) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (flush) begin
                    pc_d    = flush_pc;
                    state_d = imem_rvalid ? REQ : DROP;
                end else if (imem_rvalid) begin
                    ins_d       = imem_rdata;
                    ins_valid_d = 1'b1;
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                if (flush || ins_ready) begin
                    pc_d        = flush ? flush_pc : npc;
                    ins_valid_d = 1'b0;
                    state_d     = REQ;
                end
            end
            DROP: begin
                if (flush) pc_d = flush_pc;
                if (imem_rvalid) state_d = REQ;
            end
            default: state_d = IDLE;
        endcase
`ifdef PC_FETCH_ALIGN_CHK_EN
        imem_req_d  = (state_d == REQ) && (pc_d[1:0] == 2'b00);
        fetch_err_d = ins_valid_d && (fetch_err_q || (state_q == REQ && !imem_req_q && !flush));
`else
        imem_req_d  = (state_d == REQ);
`endif
        imem_addr_d = imem_req_d ? {pc_d[31:2], 2'b00} : imem_addr_q;
    end

    // State and output registers; reset abandons any transaction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            ins_q       <= NOP_INS;
            ins_valid_q <= 1'b0;
            imem_req_q  <= 1'b0;
            imem_addr_q <= 32'h0;
`ifdef PC_FETCH_ALIGN_CHK_EN
            fetch_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ins_q       <= ins_d;
            ins_valid_q <= ins_valid_d;
            imem_req_q  <= imem_req_d;
            imem_addr_q <= imem_addr_d;
`ifdef PC_FETCH_ALIGN_CHK_EN
            fetch_err_q <= fetch_err_d;
`endif
        end
    end

    assign pc        = pc_q;
    assign ins       = ins_q;
    assign ins_valid = ins_valid_q;
    assign imem_req  = imem_req_q;
    assign imem_addr = imem_addr_q;
`ifdef PC_FETCH_ALIGN_CHK_EN
    assign fetch_err = fetch_err_q;
`else
    assign fetch_err = 1'b0;
`endif

    // A response is only legal while a grant is outstanding (WAIT/DROP) or ignorable (IDLE)
    a_no_stray_rvalid : assert property (@(posedge clk) disable iff (!rst_n)
        !(imem_rvalid && (state_q == REQ || state_q == HOLD)));

endmodule
